// File: rtl/ysyx_040066_mem_arbiter.sv
// Memory-bus arbiter: grants one of NUM_CH masters a whole read or write transaction
// on the single downstream port, serialises write lines into beats and routes read beats back.
module ysyx_040066_mem_arbiter #(
  parameter int  NUM_CH    = 3,
  parameter int  ADDR_W    = 64,
  parameter int  DATA_W    = 64,
  parameter int  MAX_BEATS = 8,
  parameter int  PRIO_MODE = 0,
  parameter int  TIMEOUT   = 255,
  localparam int LEN_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CH-1:0]                   m_req,
  input  logic [NUM_CH-1:0]                   m_we,
  input  logic [NUM_CH-1:0]                   m_burst,
  input  logic [NUM_CH*LEN_W-1:0]             m_len,
  input  logic [NUM_CH*ADDR_W-1:0]            m_addr,
  input  logic [NUM_CH*DATA_W/8-1:0]          m_mask,
  input  logic [NUM_CH*MAX_BEATS*DATA_W-1:0]  m_wdata,
  output logic [NUM_CH-1:0]                   m_ready,
  output logic [NUM_CH-1:0]                   m_last,
  output logic [NUM_CH-1:0]                   m_err,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic                                s_valid,
  output logic                                s_we,
  output logic                                s_burst,
  output logic [LEN_W-1:0]                    s_len,
  output logic [ADDR_W-1:0]                   s_addr,
  output logic [DATA_W/8-1:0]                 s_mask,
  output logic [DATA_W-1:0]                   s_wdata,
  output logic                                s_wlast,
  input  logic                                s_ready,
  input  logic [DATA_W-1:0]                   s_rdata,
  input  logic                                s_last,
  input  logic                                s_err
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MASK_W = DATA_W / 8;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r, state_n;
  logic [CH_W-1:0]     g_r, last_grant_r, grant_s;
  logic                we_r, burst_r;
  logic [LEN_W-1:0]    len_r, cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [MASK_W-1:0]   mask_r;
  logic [TO_W-1:0]     to_r;
  logic                sel_we_s, sel_burst_s;
  logic [LEN_W-1:0]    sel_len_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [MASK_W-1:0]   sel_mask_s;
  logic [DATA_W-1:0]   wbeat_s;
  logic [NUM_CH-1:0]   g_oh_s;
  logic                do_grant_s, cnt_inc_s, to_inc_s, to_clr_s, cap_rd_s;
  logic                rsp_rdy_s, rsp_last_s, rsp_err_s, timeout_s;

  assign g_oh_s    = NUM_CH'(1'b1) << g_r;
  assign timeout_s = (TIMEOUT != 0) && (to_r == TO_W'(TIMEOUT - 1));

  // Grant selection: reverse scan so the last assignment is the winner of the search order
  always_comb begin
    grant_s = '0;
    if (PRIO_MODE == 1) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        grant_s = m_req[c] ? CH_W'(c) : grant_s;
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        for (int c = 0; c < NUM_CH; c++) begin
          grant_s = (m_req[c] && (c == (int'(last_grant_r) + k) % NUM_CH)) ? CH_W'(c) : grant_s;
        end
      end
    end
  end

  // Per-master request fields of the candidate grant
  always_comb begin
    sel_we_s    = 1'b0;
    sel_burst_s = 1'b0;
    sel_len_s   = '0;
    sel_addr_s  = '0;
    sel_mask_s  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_we_s    = (grant_s == CH_W'(c)) ? m_we[c]                        : sel_we_s;
      sel_burst_s = (grant_s == CH_W'(c)) ? m_burst[c]                     : sel_burst_s;
      sel_len_s   = (grant_s == CH_W'(c)) ? m_len[c*LEN_W +: LEN_W]        : sel_len_s;
      sel_addr_s  = (grant_s == CH_W'(c)) ? m_addr[c*ADDR_W +: ADDR_W]     : sel_addr_s;
      sel_mask_s  = (grant_s == CH_W'(c)) ? m_mask[c*MASK_W +: MASK_W]     : sel_mask_s;
    end
  end

  // Current write beat, taken live from the granted master's line
  always_comb begin
    wbeat_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < MAX_BEATS; b++) begin
        wbeat_s = (g_r == CH_W'(c) && cnt_r == LEN_W'(b)) ?
                  m_wdata[(c*MAX_BEATS + b)*DATA_W +: DATA_W] : wbeat_s;
      end
    end
  end

  // Next-state and transaction control
  always_comb begin
    state_n    = state_r;
    do_grant_s = 1'b0;
    cnt_inc_s  = 1'b0;
    to_inc_s   = 1'b0;
    to_clr_s   = 1'b0;
    cap_rd_s   = 1'b0;
    rsp_rdy_s  = 1'b0;
    rsp_last_s = 1'b0;
    rsp_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (|m_req) begin
          do_grant_s = 1'b1;
          state_n    = sel_we_s ? WRITE : READ;
        end else begin
          state_n = IDLE;
        end
      end
      READ, WRITE: begin
        if (s_ready) begin
          to_clr_s = 1'b1;
          cap_rd_s = (state_r == READ);
          // error wins over a simultaneous s_last
          if (s_err) begin
            rsp_rdy_s  = 1'b1;
            rsp_last_s = 1'b1;
            rsp_err_s  = 1'b1;
            state_n    = DONE;
          end else if (cnt_r == len_r || (state_r == READ && s_last)) begin
            rsp_rdy_s  = 1'b1;
            rsp_last_s = 1'b1;
            state_n    = DONE;
          end else begin
            rsp_rdy_s  = (state_r == READ);
            cnt_inc_s  = 1'b1;
          end
        end else if (timeout_s) begin
          rsp_rdy_s  = 1'b1;
          rsp_last_s = 1'b1;
          rsp_err_s  = 1'b1;
          state_n    = DONE;
        end else begin
          to_inc_s = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Latched transaction fields, counters and registered master responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_r          <= '0;
      last_grant_r <= CH_W'(NUM_CH - 1);
      we_r         <= 1'b0;
      burst_r      <= 1'b0;
      len_r        <= '0;
      addr_r       <= '0;
      mask_r       <= '0;
      cnt_r        <= '0;
      to_r         <= '0;
      m_ready      <= '0;
      m_last       <= '0;
      m_err        <= '0;
      m_rdata      <= '0;
    end else begin
      m_ready <= rsp_rdy_s  ? g_oh_s : '0;
      m_last  <= rsp_last_s ? g_oh_s : '0;
      m_err   <= rsp_err_s  ? g_oh_s : '0;
      if (cap_rd_s) begin
        m_rdata <= s_rdata;
      end
      if (do_grant_s) begin
        g_r          <= grant_s;
        last_grant_r <= grant_s;
        we_r         <= sel_we_s;
        burst_r      <= sel_burst_s;
        len_r        <= sel_burst_s ? sel_len_s : '0;
        addr_r       <= sel_addr_s;
        mask_r       <= sel_mask_s;
        cnt_r        <= '0;
        to_r         <= '0;
      end else begin
        if (cnt_inc_s) begin
          cnt_r <= cnt_r + LEN_W'(1);
        end
        if (to_clr_s) begin
          to_r <= '0;
        end else if (to_inc_s) begin
          to_r <= to_r + TO_W'(1);
        end
      end
    end
  end

  assign s_valid = (state_r == READ) || (state_r == WRITE);
  assign s_we    = we_r;
  assign s_burst = burst_r;
  assign s_len   = len_r;
  assign s_addr  = addr_r;
  assign s_mask  = mask_r;
  assign s_wdata = (state_r == WRITE) ? wbeat_s : '0;
  assign s_wlast = (state_r == WRITE) && (cnt_r == len_r);

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Scoreboard bench for ysyx_040066_mem_arbiter: a round-robin instance (TIMEOUT=4) drives the
// flow, a fixed-priority twin shares its inputs.
module tb_ysyx_040066_mem_arbiter;

  localparam int NC = 3;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      m_req, m_we, m_burst;
  logic [8:0]      m_len;
  logic [191:0]    m_addr;
  logic [23:0]     m_mask;
  logic [1535:0]   m_wdata;
  logic            s_ready, s_last, s_err;
  logic [63:0]     s_rdata;

  logic [2:0]  a_m_ready, a_m_last, a_m_err, b_m_ready, b_m_last, b_m_err;
  logic [63:0] a_m_rdata, b_m_rdata, a_s_addr, b_s_addr, a_s_wdata, b_s_wdata;
  logic        a_s_valid, a_s_we, a_s_burst, a_s_wlast, b_s_valid, b_s_we, b_s_burst, b_s_wlast;
  logic [2:0]  a_s_len, b_s_len;
  logic [7:0]  a_s_mask, b_s_mask;

  ysyx_040066_mem_arbiter #(.NUM_CH(3), .ADDR_W(64), .DATA_W(64), .MAX_BEATS(8),
                            .PRIO_MODE(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_burst(m_burst), .m_len(m_len),
    .m_addr(m_addr), .m_mask(m_mask), .m_wdata(m_wdata), .m_ready(a_m_ready),
    .m_last(a_m_last), .m_err(a_m_err), .m_rdata(a_m_rdata), .s_valid(a_s_valid),
    .s_we(a_s_we), .s_burst(a_s_burst), .s_len(a_s_len), .s_addr(a_s_addr),
    .s_mask(a_s_mask), .s_wdata(a_s_wdata), .s_wlast(a_s_wlast), .s_ready(s_ready),
    .s_rdata(s_rdata), .s_last(s_last), .s_err(s_err));

  ysyx_040066_mem_arbiter #(.NUM_CH(3), .ADDR_W(64), .DATA_W(64), .MAX_BEATS(8),
                            .PRIO_MODE(1), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_burst(m_burst), .m_len(m_len),
    .m_addr(m_addr), .m_mask(m_mask), .m_wdata(m_wdata), .m_ready(b_m_ready),
    .m_last(b_m_last), .m_err(b_m_err), .m_rdata(b_m_rdata), .s_valid(b_s_valid),
    .s_we(b_s_we), .s_burst(b_s_burst), .s_len(b_s_len), .s_addr(b_s_addr),
    .s_mask(b_s_mask), .s_wdata(b_s_wdata), .s_wlast(b_s_wlast), .s_ready(s_ready),
    .s_rdata(s_rdata), .s_last(s_last), .s_err(s_err));

  typedef struct packed {
    logic [2:0]  rdy;
    logic [2:0]  lst;
    logic [2:0]  er;
    logic        chk;
    logic [63:0] dat;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t e;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [63:0] addr_of(input int c);
    return 64'h1000 * 64'(c + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req = 3'b000; m_we = 3'b000; m_burst = 3'b000; m_len = 9'd0;
    m_addr = 192'd0; m_mask = 24'd0; m_wdata = 1536'd0;
    s_ready = 1'b0; s_last = 1'b0; s_err = 1'b0; s_rdata = 64'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({a_m_ready, a_m_last, a_m_err, a_m_rdata, a_s_valid, a_s_we, a_s_burst, a_s_len,
         a_s_addr, a_s_mask, a_s_wdata, a_s_wlast} !== '0) begin
      bad++;
      $display("FAIL reset_a: outputs not all zero, s_valid=%b m_ready=%b s_addr=%h", a_s_valid, a_m_ready, a_s_addr);
    end
    total++;
    if ({b_m_ready, b_m_last, b_m_err, b_s_valid, b_s_addr, b_s_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_b: outputs not all zero, s_valid=%b m_ready=%b", b_s_valid, b_m_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    total++;
    if (a_s_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: s_valid=%b want 0 with no request", a_s_valid);
    end
  endtask

  task automatic test_single_read();
    m_len[5:3] = 3'd5;
    m_addr[127:64] = 64'h8000_1000;
    m_req = 3'b010;
    tick();
    total++;
    if (a_s_valid !== 1'b1 || a_s_addr !== 64'h8000_1000 || a_s_len !== 3'd0 || a_s_we !== 1'b0) begin
      bad++;
      $display("FAIL sr_req: s_valid=%b s_addr=%h s_len=%0d s_we=%b, want 1/80001000/0/0", a_s_valid, a_s_addr, a_s_len, a_s_we);
    end
    s_ready = 1'b1; s_rdata = 64'hDEAD_BEEF; s_last = 1'b0;
    exp_q.push_back('{3'b010, 3'b010, 3'b000, 1'b1, 64'hDEAD_BEEF});
    tick();
    s_ready = 1'b0; m_req = 3'b000;
    total++;
    if (exp_q.size() == 0 || a_m_ready === 3'b000) begin
      bad++;
      $display("FAIL sr_rsp: m_ready=%b, want a pending response", a_m_ready);
    end else begin
      e = exp_q.pop_front();
      if ({a_m_ready, a_m_last, a_m_err} !== {e.rdy, e.lst, e.er} || a_m_rdata !== e.dat) begin
        bad++;
        $display("FAIL sr_rsp: rdy/last/err=%b/%b/%b data=%h, want %b/%b/%b data=%h", a_m_ready, a_m_last, a_m_err, a_m_rdata, e.rdy, e.lst, e.er, e.dat);
      end
    end
    total++;
    if (a_s_valid !== 1'b0) begin
      bad++;
      $display("FAIL sr_done: s_valid=%b want 0", a_s_valid);
    end
    tick();
    total++;
    if (a_m_ready !== 3'b000 || a_m_last !== 3'b000) begin
      bad++;
      $display("FAIL sr_pulse: m_ready=%b m_last=%b, want 000/000", a_m_ready, a_m_last);
    end
  endtask

  task automatic test_burst_write();
    int n_rsp;
    n_rsp = 0;
    for (int i = 0; i < 8; i++) m_wdata[(8 + i)*64 +: 64] = 64'(i);
    m_mask[15:8] = 8'hA5;
    m_addr[127:64] = 64'h8000_2000;
    m_we = 3'b010; m_burst = 3'b010; m_len[5:3] = 3'd7;
    m_req = 3'b010;
    tick();
    total++;
    if (a_s_we !== 1'b1 || a_s_burst !== 1'b1 || a_s_len !== 3'd7 || a_s_mask !== 8'hA5 || a_s_addr !== 64'h8000_2000) begin
      bad++;
      $display("FAIL bw_hdr: we=%b burst=%b len=%0d mask=%h addr=%h, want 1/1/7/a5/80002000", a_s_we, a_s_burst, a_s_len, a_s_mask, a_s_addr);
    end
    for (int b = 0; b < 8; b++) begin
      total++;
      if (a_s_valid !== 1'b1 || a_s_wdata !== 64'(b) || a_s_wlast !== (b == 7)) begin
        bad++;
        $display("FAIL bw_beat%0d: valid=%b wdata=%h wlast=%b, want 1/%h/%b", b, a_s_valid, a_s_wdata, a_s_wlast, 64'(b), (b == 7));
      end
      s_ready = 1'b1;
      if (b == 4) m_req = 3'b000;
      if (b == 7) exp_q.push_back('{3'b010, 3'b010, 3'b000, 1'b0, 64'd0});
      tick();
      s_ready = 1'b0;
      if (a_m_ready !== 3'b000) begin
        n_rsp++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bw_rsp: early m_ready=%b after beat %0d", a_m_ready, b);
        end else begin
          e = exp_q.pop_front();
          if ({a_m_ready, a_m_last, a_m_err} !== {e.rdy, e.lst, e.er}) begin
            bad++;
            $display("FAIL bw_rsp: rdy/last/err=%b/%b/%b, want %b/%b/%b", a_m_ready, a_m_last, a_m_err, e.rdy, e.lst, e.er);
          end
        end
      end
    end
    total++;
    if (n_rsp !== 1 || exp_q.size() != 0 || a_s_valid !== 1'b0) begin
      bad++;
      $display("FAIL bw_end: responses=%0d pending=%0d s_valid=%b, want 1/0/0", n_rsp, exp_q.size(), a_s_valid);
    end
    m_we = 3'b000; m_burst = 3'b000;
    tick();
  endtask

  task automatic test_round_robin();
    int eo[4] = '{0, 1, 2, 0};
    int n_done, last_beat;
    do_reset();
    for (int c = 0; c < NC; c++) m_addr[c*64 +: 64] = addr_of(c);
    m_req = 3'b111;
    n_done = 0; last_beat = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      tick();
      s_ready = 1'b0;
      if (a_m_ready !== 3'b000) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rr_rsp: unexpected m_ready=%b", a_m_ready);
        end else begin
          e = exp_q.pop_front();
          if ({a_m_ready, a_m_last, a_m_err} !== {e.rdy, e.lst, e.er} || a_m_rdata !== e.dat || b_m_ready !== 3'b001) begin
            bad++;
            $display("FAIL rr_rsp: rdy=%b last=%b data=%h prio_rdy=%b, want %b/%b/%h/001", a_m_ready, a_m_last, a_m_rdata, b_m_ready, e.rdy, e.lst, e.dat);
          end
        end
      end
      if (n_done == 4 && exp_q.size() == 0) break;
      if (a_s_valid === 1'b1 && n_done < 4) begin
        if (n_done > 0) begin
          total++;
          if (cyc - last_beat !== 3) begin
            bad++;
            $display("FAIL rr_gap: %0d cycles from final beat to s_valid, want 3", cyc - last_beat);
          end
        end
        total++;
        if (a_s_addr !== addr_of(eo[n_done]) || b_s_addr !== addr_of(0) || b_s_valid !== 1'b1) begin
          bad++;
          $display("FAIL rr_grant%0d: rr addr=%h prio addr=%h prio valid=%b, want %h/%h/1", n_done, a_s_addr, b_s_addr, b_s_valid, addr_of(eo[n_done]), addr_of(0));
        end
        s_ready = 1'b1;
        s_rdata = 64'hA0 + 64'(n_done);
        exp_q.push_back('{3'(1 << eo[n_done]), 3'(1 << eo[n_done]), 3'b000, 1'b1, 64'hA0 + 64'(n_done)});
        last_beat = cyc;
        n_done++;
      end
    end
    m_req = 3'b000;
    total++;
    if (n_done !== 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rr_count: transactions=%0d pending=%0d, want 4/0", n_done, exp_q.size());
    end
    tick();
  endtask

  task automatic test_read_error();
    tick();
    m_burst = 3'b100; m_len[8:6] = 3'd3; m_addr[191:128] = 64'h8000_3000;
    m_req = 3'b100;
    tick();
    total++;
    if (a_s_valid !== 1'b1 || a_s_len !== 3'd3 || a_s_addr !== 64'h8000_3000) begin
      bad++;
      $display("FAIL re_req: valid=%b len=%0d addr=%h, want 1/3/80003000", a_s_valid, a_s_len, a_s_addr);
    end
    for (int b = 0; b < 2; b++) begin
      s_ready = 1'b1; s_err = (b == 1); s_rdata = (b == 0) ? 64'h1111 : 64'h2222;
      exp_q.push_back('{3'b100, (b == 1) ? 3'b100 : 3'b000, (b == 1) ? 3'b100 : 3'b000, 1'b1, s_rdata});
      tick();
      s_ready = 1'b0; s_err = 1'b0;
      total++;
      if (exp_q.size() == 0 || a_m_ready === 3'b000) begin
        bad++;
        $display("FAIL re_beat%0d: m_ready=%b, want a pending response", b, a_m_ready);
      end else begin
        e = exp_q.pop_front();
        if ({a_m_ready, a_m_last, a_m_err} !== {e.rdy, e.lst, e.er} || a_m_rdata !== e.dat || a_s_valid !== (b == 0)) begin
          bad++;
          $display("FAIL re_beat%0d: rdy/last/err=%b/%b/%b data=%h valid=%b, want %b/%b/%b data=%h valid=%b", b, a_m_ready, a_m_last, a_m_err, a_m_rdata, a_s_valid, e.rdy, e.lst, e.er, e.dat, (b == 0));
        end
      end
    end
    m_req = 3'b000; m_burst = 3'b000;
    tick();
    m_req = 3'b001;
    tick();
    total++;
    if (a_s_valid !== 1'b1 || a_m_ready !== 3'b000) begin
      bad++;
      $display("FAIL re_idle: new request s_valid=%b m_ready=%b, want 1/000", a_s_valid, a_m_ready);
    end
  endtask

  task automatic test_timeout();
    int n_valid;
    bit got;
    do_reset();
    m_addr[63:0] = 64'h4000;
    m_req = 3'b001;
    tick();
    n_valid = 0; got = 1'b0;
    exp_q.push_back('{3'b001, 3'b001, 3'b001, 1'b0, 64'd0});
    for (int i = 0; i < 20; i++) begin
      if (a_s_valid === 1'b1) n_valid++;
      if (a_m_ready !== 3'b000) begin
        got = 1'b1;
        total++;
        e = exp_q.pop_front();
        if ({a_m_ready, a_m_last, a_m_err} !== {e.rdy, e.lst, e.er} || a_s_valid !== 1'b0) begin
          bad++;
          $display("FAIL to_rsp: rdy/last/err=%b/%b/%b valid=%b, want %b/%b/%b valid=0", a_m_ready, a_m_last, a_m_err, a_s_valid, e.rdy, e.lst, e.er);
        end
        break;
      end
      tick();
    end
    m_req = 3'b000;
    total++;
    if (!got || n_valid !== 4) begin
      bad++;
      $display("FAIL to_len: abort seen=%b after %0d valid cycles, want 1 after 4", got, n_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m_burst = 3'b010; m_len[5:3] = 3'd7; m_addr[127:64] = 64'h5000;
    m_req = 3'b010;
    tick();
    s_ready = 1'b1; s_rdata = 64'h55;
    tick();
    tick();
    #2;
    total++;
    if (a_s_valid !== 1'b1 || a_m_ready !== 3'b010) begin
      bad++;
      $display("FAIL rm_busy: s_valid=%b m_ready=%b mid-burst, want 1/010", a_s_valid, a_m_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({a_m_ready, a_m_last, a_m_err, a_m_rdata, a_s_valid, a_s_we, a_s_burst, a_s_len,
         a_s_addr, a_s_mask, a_s_wdata, a_s_wlast} !== '0) begin
      bad++;
      $display("FAIL rm_async: outputs not zero, s_valid=%b m_ready=%b m_rdata=%h s_addr=%h", a_s_valid, a_m_ready, a_m_rdata, a_s_addr);
    end
    exp_q.delete();
    s_ready = 1'b0; m_burst = 3'b000;
    m_addr[63:0] = 64'h6000; m_addr[191:128] = 64'h7000;
    m_req = 3'b111;
    @(negedge clk);
    rst = 1'b1;
    tick();
    total++;
    if (a_s_valid !== 1'b1 || a_s_addr !== 64'h6000) begin
      bad++;
      $display("FAIL rm_first: s_valid=%b s_addr=%h, want 1/6000", a_s_valid, a_s_addr);
    end
    m_req = 3'b000;
    s_ready = 1'b1; s_rdata = 64'h66;
    exp_q.push_back('{3'b001, 3'b001, 3'b000, 1'b1, 64'h66});
    tick();
    s_ready = 1'b0;
    total++;
    if (exp_q.size() == 0 || a_m_ready === 3'b000) begin
      bad++;
      $display("FAIL rm_rsp: m_ready=%b, want a pending response", a_m_ready);
    end else begin
      e = exp_q.pop_front();
      if ({a_m_ready, a_m_last, a_m_err} !== {e.rdy, e.lst, e.er} || a_m_rdata !== e.dat) begin
        bad++;
        $display("FAIL rm_rsp: rdy/last/err=%b/%b/%b data=%h, want %b/%b/%b data=%h", a_m_ready, a_m_last, a_m_err, a_m_rdata, e.rdy, e.lst, e.er, e.dat);
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_round_robin();
    test_read_error();
    test_timeout();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_040066_mem_arbiter.md
# ysyx_040066_mem_arbiter

Parametrised memory-bus arbiter between the core's cache/uncached request channels (icache refill, dcache refill/writeback, uncached MMIO) and the single downstream memory port. It generalises the fixed ins/rd/wr channel split to `NUM_CH` masters. Each master issues a whole read or write transaction of up to `MAX_BEATS` beats. The arbiter grants one master at a time, serialises write lines into beats, routes read beats back, and aborts on bus error or timeout.

## Interface
- `NUM_CH`, 3: number of upstream masters; channel 0 is the icache by convention.
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: beat width; the mask is `DATA_W/8` bits.
- `MAX_BEATS`, 8: maximum beats per burst. `LEN_W` = clog2(`MAX_BEATS`).
- `PRIO_MODE`, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- `TIMEOUT`, 255: number of cycles without `s_ready` before a transaction aborts. 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  **asynchronous, active-low** reset.
- `m_req`  in  NUM_CH  per-master request; held high until that master's `m_last`.
- `m_we`  in  NUM_CH  1 = write transaction.
- `m_burst`  in  NUM_CH  1 = burst; 0 = single beat, and `m_len` is ignored.
- `m_len`  in  NUM_CH*LEN_W  beats-1 per master.
- `m_addr`  in  NUM_CH*ADDR_W  start address per master.
- `m_mask`  in  NUM_CH*DATA_W/8  byte mask, applied to every write beat.
- `m_wdata`  in  NUM_CH*MAX_BEATS*DATA_W  write line per master; beat i = bits [i*DATA_W +: DATA_W].
- `m_ready`  out  NUM_CH  one-cycle pulse: read beat valid, or write complete.
- `m_last`  out  NUM_CH  pulse marking the final response of a transaction.
- `m_err`  out  NUM_CH  pulse with `m_last` when the transaction was aborted.
- `m_rdata`  out  DATA_W  read beat data, shared by all masters and qualified by `m_ready`.
- `s_valid`  out  1  downstream transaction active.
- `s_we`  out  1  write flag.
- `s_burst`  out  1  burst flag.
- `s_len`  out  LEN_W  beats-1.
- `s_addr`  out  ADDR_W  start address.
- `s_mask`  out  DATA_W/8  write byte mask.
- `s_wdata`  out  DATA_W  current write beat.
- `s_wlast`  out  1  current write beat is the final beat.
- `s_ready`  in  1  beat accepted (write) or beat returned (read).
- `s_rdata`  in  DATA_W  read beat data.
- `s_last`  in  1  final read beat.
- `s_err`  in  1  bus error, qualified by `s_ready`.

## Operation
States:
- **IDLE**: if any `m_req` is high, select the grant, latch the channel index, `m_we`, `m_burst`, `m_len` (forced to 0 when `m_burst`=0), `m_addr` and `m_mask`, clear the beat and timeout counters, then go to READ or WRITE. Otherwise stay in IDLE.
- **READ**: `s_valid`=1. On `s_ready`, register `s_rdata` into `m_rdata` and pulse `m_ready[g]` next cycle.
  - If `s_err`, also pulse `m_last[g]` and `m_err[g]`, and go to DONE.
  - Else if `s_last` or the beat counter == latched len, also pulse `m_last[g]` and go to DONE.
  - Otherwise increment the beat counter.
- **WRITE**: `s_valid`=1. `s_wdata` = beat[count] of master g's `m_wdata`, sampled live. `s_wlast` = (count == len). On `s_ready`, increment count.
  - After the final beat, or on `s_err`, pulse `m_ready`/`m_last` (plus `m_err` on error) and go to DONE.
- **DONE**: one cycle with `s_valid`=0, then IDLE. This gives the master one cycle to drop `m_req` before arbitration.

Arbitration and abort rules:
- Round-robin searches from `last_grant+1` modulo `NUM_CH`; `last_grant` updates on each grant. In fixed-priority mode `last_grant` is unused.
- Timeout counter: increments each READ/WRITE cycle without `s_ready` and clears on `s_ready`. When it reaches `TIMEOUT`, abort as on `s_err`; `s_valid` drops in DONE.
- `m_req[g]` falling mid-transaction is ignored; the downstream transaction still completes or aborts normally.
- Non-granted masters see `m_ready`/`m_last`/`m_err` = 0.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `last_grant`=NUM_CH-1 so channel 0 wins first. All outputs are 0, including `m_rdata`, `s_addr` and `s_wdata`.
- Grant latency: `m_req` high at edge t in IDLE gives `s_valid` and a stable `s_addr`/`s_len` from t+1, held until DONE.
- Response latency: a downstream beat at edge k produces `m_ready`/`m_rdata` at k+1 (registered); `m_last` pulses in the same cycle as its `m_ready`.
- Minimum inter-transaction gap: final beat at k, DONE at k+1, IDLE at k+2, next `s_valid` at k+3.
- Simultaneous `s_err` and `s_last` are treated as an error. A single beat (len 0) completes after one `s_ready`.

## Test plan
- Single read, ch1, non-burst, addr 0x8000_1000: one `s_ready` with `s_rdata`=0xDEAD_BEEF → `m_ready[1]` and `m_last[1]` pulse one cycle later, `m_rdata`=0xDEAD_BEEF, `s_len`=0.
- 8-beat burst write, ch1, `m_wdata` beat i = i: `s_wdata` steps 0..7, `s_wlast` is high only on beat 7, and exactly one `m_ready[1]`+`m_last[1]` pulse follows.
- All three channels request continuously in round-robin mode after reset: grants go 0,1,2,0, with a 3-cycle gap from one transaction's final beat to the next `s_valid`. With `PRIO_MODE`=1, ch0 wins every time.
- 4-beat read with `s_err` on beat 2: the master gets `m_ready` for beats 1–2, then `m_err`+`m_last` on beat 2, and the state returns to IDLE.
- `TIMEOUT`=4 and `s_ready` held low: abort 4 cycles after `s_valid`, `m_err` pulses, `s_valid` drops the following cycle.
- `rst` asserted mid-burst: every output is 0 immediately, asynchronously; after release, ch0 is granted first.
